// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and the register-dependence hazard rule for pipeline control.
package pipe_ctrl_pkg;

   localparam logic [1:0] TUSE_NONE = 2'd3;
   localparam logic       MD_MULT   = 1'b0;
   localparam logic       MD_DIV    = 1'b1;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   // A source collides with a producer when it names the same non-zero register
   // and the result arrives later than the consumer needs it.
   function automatic logic reg_hazard(input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input logic [4:0] wa,
                                       input logic [1:0] tnew);
      logic hit;
      hit = 1'b0;
      if ((src != 5'd0) && (tuse != TUSE_NONE) && (src == wa) && (tnew > tuse)) begin
         hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Down-counter modelling the occupancy of the multi-cycle mult/div unit.
module md_busy_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic op,
   output logic busy
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             idle;

   assign idle = (cnt_q == '0);

   // A start while the unit is still counting is dropped, not queued.
   always_comb begin
      cnt_d = cnt_q;
      if (start && idle) begin
         cnt_d = (op == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (!idle) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = !idle;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush control: operand hazards, mult/div occupancy and a stall counter.
module hazard_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic [1:0]  d_tuse_rs,
   input  logic [1:0]  d_tuse_rt,
   input  logic        d_is_md,
   input  logic [4:0]  e_wa,
   input  logic [1:0]  e_tnew,
   input  logic [4:0]  m_wa,
   input  logic [1:0]  m_tnew,
   input  logic        e_md_start,
   input  logic        e_md_op,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_flush,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);

   logic        hz_e_rs;
   logic        hz_e_rt;
   logic        hz_m_rs;
   logic        hz_m_rt;
   logic        md_stall;
   logic        stall;
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_counter (
      .clk   (clk),
      .reset (reset),
      .start (e_md_start),
      .op    (e_md_op),
      .busy  (md_busy)
   );

   always_comb begin
      hz_e_rs = reg_hazard(d_rs, d_tuse_rs, e_wa, e_tnew);
      hz_e_rt = reg_hazard(d_rt, d_tuse_rt, e_wa, e_tnew);
      hz_m_rs = reg_hazard(d_rs, d_tuse_rs, m_wa, m_tnew);
      hz_m_rt = reg_hazard(d_rt, d_tuse_rt, m_wa, m_tnew);
   end

   // The start cycle itself must stall too: md_busy only rises one cycle later.
   assign md_stall = d_is_md && (md_busy || e_md_start);
   assign stall    = hz_e_rs || hz_e_rt || hz_m_rs || hz_m_rt || md_stall;

   assign pc_en    = !stall;
   assign fd_en    = !stall;
   assign de_flush = stall;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl against a cycle-indexed reference model.
module tb_hazard_stall_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  d_rs;
   logic [4:0]  d_rt;
   logic [1:0]  d_tuse_rs;
   logic [1:0]  d_tuse_rt;
   logic        d_is_md;
   logic [4:0]  e_wa;
   logic [1:0]  e_tnew;
   logic [4:0]  m_wa;
   logic [1:0]  m_tnew;
   logic        e_md_start;
   logic        e_md_op;
   logic        pc_en;
   logic        fd_en;
   logic        de_flush;
   logic        md_busy;
   logic [31:0] stall_cnt;

   int n_vec;
   int n_err;

   // Reference model: the unit is busy through cycle m_busy_end inclusive.
   int      m_cycle;
   int      m_busy_end;
   longint  m_cnt;

   hazard_stall_ctrl #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10),
      .CNT_W       (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_is_md    (d_is_md),
      .e_wa       (e_wa),
      .e_tnew     (e_tnew),
      .m_wa       (m_wa),
      .m_tnew     (m_tnew),
      .e_md_start (e_md_start),
      .e_md_op    (e_md_op),
      .pc_en      (pc_en),
      .fd_en      (fd_en),
      .de_flush   (de_flush),
      .md_busy    (md_busy),
      .stall_cnt  (stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic ref_busy();
      return m_cycle <= m_busy_end;
   endfunction

   function automatic logic hz(input logic [4:0] src, input logic [1:0] tuse,
                               input logic [4:0] wa, input logic [1:0] tnew);
      return (src != 5'd0) && (src == wa) && (int'(tnew) > int'(tuse));
   endfunction

   function automatic logic ref_stall();
      logic s;
      s = hz(d_rs, d_tuse_rs, e_wa, e_tnew) || hz(d_rt, d_tuse_rt, e_wa, e_tnew) ||
          hz(d_rs, d_tuse_rs, m_wa, m_tnew) || hz(d_rt, d_tuse_rt, m_wa, m_tnew);
      return s || (d_is_md && (ref_busy() || e_md_start));
   endfunction

   task automatic clear_inputs();
      reset = 1'b0; d_rs = '0; d_rt = '0; d_tuse_rs = '0; d_tuse_rt = '0; d_is_md = 1'b0;
      e_wa = '0; e_tnew = '0; m_wa = '0; m_tnew = '0; e_md_start = 1'b0; e_md_op = 1'b0;
   endtask

   // One clock edge; advances the model with the inputs present at the edge.
   task automatic tick();
      logic s;
      s = ref_stall();
      @(posedge clk);
      if (reset) begin
         m_busy_end = m_cycle;
         m_cnt      = 0;
      end else begin
         if (e_md_start && !ref_busy()) m_busy_end = m_cycle + (e_md_op ? 10 : 5);
         if (s && (m_cnt < 64'h0000_0000_FFFF_FFFF)) m_cnt = m_cnt + 1;
      end
      m_cycle = m_cycle + 1;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      n_vec++;
      if ({pc_en, fd_en, de_flush, md_busy} !== 4'b1100) begin
         n_err++;
         $display("FAIL reset_ctl: got %b want 1100", {pc_en, fd_en, de_flush, md_busy});
      end
      n_vec++;
      if (stall_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
      end
   endtask

   task automatic test_load_use();
      clear_inputs();
      d_rs = 5'd5; d_tuse_rs = 2'd0; e_wa = 5'd5; e_tnew = 2'd2;
      #1;
      n_vec++;
      if ({pc_en, fd_en, de_flush} !== 3'b001) begin
         n_err++;
         $display("FAIL load_use: got %b want 001", {pc_en, fd_en, de_flush});
      end
      e_tnew = 2'd0;
      #1;
      n_vec++;
      if (pc_en !== 1'b1) begin
         n_err++;
         $display("FAIL load_use_resolved: pc_en got %b want 1", pc_en);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_zero_reg();
      clear_inputs();
      d_rs = 5'd0; e_wa = 5'd0; e_tnew = 2'd2;
      #1;
      n_vec++;
      if (de_flush !== 1'b0) begin
         n_err++;
         $display("FAIL zero_reg: de_flush got %b want 0", de_flush);
      end
      clear_inputs();
      d_rt = 5'd7; d_tuse_rt = 2'd3; m_wa = 5'd7; m_tnew = 2'd2;
      #1;
      n_vec++;
      if (pc_en !== 1'b1) begin
         n_err++;
         $display("FAIL tuse_none: pc_en got %b want 1", pc_en);
      end
      tick();
   endtask

   task automatic test_m_stage();
      clear_inputs();
      d_rt = 5'd9; d_tuse_rt = 2'd0; m_wa = 5'd9; m_tnew = 2'd1;
      #1;
      n_vec++;
      if (de_flush !== 1'b1) begin
         n_err++;
         $display("FAIL m_stage: de_flush got %b want 1", de_flush);
      end
      tick();
      clear_inputs();
      #1;
      n_vec++;
      if (stall_cnt !== 32'd1) begin
         n_err++;
         $display("FAIL m_stage_cnt: got %0d want 1", stall_cnt);
      end
      tick();
   endtask

   task automatic test_div_busy();
      clear_inputs();
      d_is_md = 1'b1;
      for (int k = 0; k <= 11; k++) begin
         e_md_start = (k == 0) || (k == 3);
         e_md_op    = (k == 0);
         #1;
         n_vec++;
         if (de_flush !== (k <= 10)) begin
            n_err++;
            $display("FAIL div_stall[%0d]: got %b want %b", k, de_flush, (k <= 10));
         end
         n_vec++;
         if (md_busy !== ((k >= 1) && (k <= 10))) begin
            n_err++;
            $display("FAIL div_busy[%0d]: got %b want %b", k, md_busy, (k >= 1) && (k <= 10));
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_mult();
      clear_inputs();
      for (int k = 0; k <= 4; k++) begin
         e_md_start = (k == 0);
         reset      = (k == 3);
         #1;
         if (k >= 1 && k <= 3) begin
            n_vec++;
            if (md_busy !== 1'b1) begin
               n_err++;
               $display("FAIL mult_busy[%0d]: got %b want 1", k, md_busy);
            end
         end
         if (k == 4) begin
            n_vec++;
            if ({md_busy, stall_cnt} !== 33'd0) begin
               n_err++;
               $display("FAIL reset_mid_mult: busy %b cnt %0d want 0 0", md_busy, stall_cnt);
            end
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset_with_start();
      clear_inputs();
      reset = 1'b1; e_md_start = 1'b1; e_md_op = 1'b1;
      tick();
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
         #1;
         n_vec++;
         if (md_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_start[%0d]: md_busy got %b want 0", k, md_busy);
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      clear_inputs();
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      m_cnt = 64'h0000_0000_FFFF_FFFE;
      #1;
      n_vec++;
      if (stall_cnt !== 32'hFFFF_FFFE) begin
         n_err++;
         $display("FAIL sat_preload: got %h want fffffffe", stall_cnt);
      end
      d_rs = 5'd5; e_wa = 5'd5; e_tnew = 2'd2;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++;
         if (stall_cnt !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL sat[%0d]: got %h want ffffffff", k, stall_cnt);
         end
      end
      clear_inputs();
   endtask

   task automatic test_random();
      logic [3:0] exp_ctl;
      clear_inputs();
      reset = 1'b1;
      tick();
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(99) < 3);
         d_rs       = 5'($urandom_range(3));
         d_rt       = 5'($urandom_range(3));
         d_tuse_rs  = 2'($urandom_range(3));
         d_tuse_rt  = 2'($urandom_range(3));
         d_is_md    = ($urandom_range(3) == 0);
         e_wa       = 5'($urandom_range(3));
         e_tnew     = 2'($urandom_range(2));
         m_wa       = 5'($urandom_range(3));
         m_tnew     = 2'($urandom_range(2));
         e_md_start = ($urandom_range(4) == 0);
         e_md_op    = 1'($urandom_range(1));
         #1;
         exp_ctl = {!ref_stall(), !ref_stall(), ref_stall(), ref_busy()};
         n_vec++;
         if ({pc_en, fd_en, de_flush, md_busy} !== exp_ctl) begin
            n_err++;
            $display("FAIL rand_ctl[%0d]: got %b want %b", i,
                     {pc_en, fd_en, de_flush, md_busy}, exp_ctl);
         end
         n_vec++;
         if (stall_cnt !== m_cnt[31:0]) begin
            n_err++;
            $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, stall_cnt, m_cnt[31:0]);
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      m_cycle    = 0;
      m_busy_end = -1;
      m_cnt      = 0;
      clear_inputs();
      test_reset();
      test_load_use();
      test_zero_reg();
      test_m_stage();
      test_div_busy();
      test_reset_mid_mult();
      test_reset_with_start();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
